execute_md: RTL and testbench
=============================

EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 SHALL have parameter N, default 32: datapath width, any even value >= 8.
REQ-002 SHALL have parameter CWM, default 7: width of the MEM-stage control word.
REQ-003 SHALL have parameter RDW, default 5: width of the destination register index.
REQ-004 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pipe_en  in  1  downstream advance enable
- flush  in  1  kill current EX instruction
- valid_in  in  1  ID/EX holds a live instruction
- aluOp  in  4  single-cycle ALU operation
- md_en  in  1  instruction is mul/div
- md_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- selA  in  1  0 = NPCin, 1 = r1
- selB  in  1  0 = r2, 1 = Imm
- branch  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU
- jmp_en  in  1  unconditional jump
- forwardA, forwardB  in  2 each  00 none, 01 MEMWBRdest, 10 EXMEMRdest
- r1, r2, Imm, NPCin, NPC4_IN, MEMWBRdest, EXMEMRdest  in  N each  operands
- cwMEM_in  in  CWM  MEM control word
- Rdest_in  in  RDW  destination index
- busy  out  1  stall request to hazard unit
- ALUres, Bout, ImmOUT, NPC4_OUT, jPC  out  N each  EX/MEM registered
- cwMEM  out  CWM  EX/MEM registered
- Rdest  out  RDW  EX/MEM registered
- valid_out  out  1  EX/MEM registered
- PC_sel  out  1  EX/MEM registered redirect

Function
REQ-006 SHALL resolve operands as follows: forward muxes take precedence; forward code 11 yields muxed value; branch compare uses forwarded r1/r2 (muxes bypassed for selA/selB).
REQ-007 SHALL compute the branch as follows: BLT/BGE signed; BLTU/BGEU unsigned; branch codes 7 -> not taken.
REQ-008 SHALL compute the redirect as follows: jPC_next = NPCin + (Imm << 1) mod 2^N; PC_sel_next = valid_in & (jmp_en | taken).
REQ-009 SHALL, for a non-md instruction, produce result = ALU(operand1, operand2, aluOp), with 1-cycle latency and busy = 0.
REQ-010 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-011 SHALL transition IDLE -> RUN on accept = valid_in & md_en & pipe_en & !flush; at accept it latches both forwarded operands, md_op, sign info, and counter = 0.
REQ-012 SHALL perform one iteration per cycle in RUN: shift-add multiply (2N-bit product) or restoring divide on magnitudes, counter++; after N RUN cycles it goes to DONE.
REQ-013 SHALL in DONE apply signs and select the result: MUL low N bits; MULH*/ high N bits; DIV/DIVU quotient; REM/REMU remainder, with sign of dividend.
REQ-014 SHALL give divide-by-zero a quotient of all ones and a remainder equal to the dividend.
REQ-015 SHALL give signed overflow (-2^(N-1) / -1) a quotient of -2^(N-1) and a remainder of 0.
REQ-016 SHALL assert busy = 1 combinationally in the accept cycle and all RUN cycles (exactly N+1 cycles), and busy = 0 in DONE.
REQ-017 SHALL load the EX/MEM registers only when pipe_en & !busy; all other EX/MEM fields come from the current ID/EX inputs (held by upstream stall).
REQ-018 SHALL go DONE -> IDLE when pipe_en = 1; with pipe_en = 0 it SHALL hold DONE and the latched result.
REQ-019 SHALL ignore input changes during RUN; the result depends only on operands latched at accept.
REQ-020 SHALL, when flush = 1, take priority over everything: FSM -> IDLE, and next cycle valid_out = 0 and PC_sel = 0; other EX/MEM fields are don't-care.
REQ-021 SHALL, when valid_in = 0 and the EX/MEM registers load, set valid_out = 0 and PC_sel = 0.

Reset
REQ-022 SHALL, when rst = 1 at a clk edge (including mid-RUN), clear all registered outputs to 0, put the FSM in IDLE, and clear the counter; busy = 0 in the following cycle.
REQ-023 SHALL give rst priority over flush and pipe_en.

Verification (N = 32)
REQ-024 SHALL pass: MUL r1 = 7, r2 = 0xFFFFFFFD, pipe_en = 1 -> busy high 33 cycles; next cycle ALUres = 0xFFFFFFEB, valid_out = 1.
REQ-025 SHALL pass: DIV 0x80000000 / 0xFFFFFFFF -> ALUres = 0x80000000; REM same operands -> 0.
REQ-026 SHALL pass: DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-027 SHALL pass: r1 = 1, r2 = 0xFFFFFFFF: BLTU -> PC_sel = 1, jPC = NPCin + 2*Imm; BLT -> PC_sel = 0.
REQ-028 SHALL pass: flush at RUN cycle 10 -> busy = 0 next cycle, valid_out = 0; a following ADD completes in 1 cycle.
REQ-029 SHALL pass: DIV accepted, then forwardA changes during RUN and pipe_en is held low in DONE for 3 cycles -> result unchanged, loaded when pipe_en returns to 1.

Source files
------------

// File: rtl/execute_md_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage with mul/div unit.
interface execute_md_if #(
  parameter int N   = 32,
  parameter int CWM = 7,
  parameter int RDW = 5
);
  logic           pipe_en;
  logic           flush;
  logic           valid_in;
  logic [3:0]     aluOp;
  logic           md_en;
  logic [2:0]     md_op;
  logic           selA;
  logic           selB;
  logic [2:0]     branch;
  logic           jmp_en;
  logic [1:0]     forwardA;
  logic [1:0]     forwardB;
  logic [N-1:0]   r1;
  logic [N-1:0]   r2;
  logic [N-1:0]   Imm;
  logic [N-1:0]   NPCin;
  logic [N-1:0]   NPC4_IN;
  logic [N-1:0]   MEMWBRdest;
  logic [N-1:0]   EXMEMRdest;
  logic [CWM-1:0] cwMEM_in;
  logic [RDW-1:0] Rdest_in;

  logic           busy;
  logic [N-1:0]   ALUres;
  logic [N-1:0]   Bout;
  logic [N-1:0]   ImmOUT;
  logic [N-1:0]   NPC4_OUT;
  logic [N-1:0]   jPC;
  logic [CWM-1:0] cwMEM;
  logic [RDW-1:0] Rdest;
  logic           valid_out;
  logic           PC_sel;

  modport master (
    output pipe_en, flush, valid_in, aluOp, md_en, md_op, selA, selB, branch,
           jmp_en, forwardA, forwardB, r1, r2, Imm, NPCin, NPC4_IN,
           MEMWBRdest, EXMEMRdest, cwMEM_in, Rdest_in,
    input  busy, ALUres, Bout, ImmOUT, NPC4_OUT, jPC, cwMEM, Rdest,
           valid_out, PC_sel
  );

  modport slave (
    input  pipe_en, flush, valid_in, aluOp, md_en, md_op, selA, selB, branch,
           jmp_en, forwardA, forwardB, r1, r2, Imm, NPCin, NPC4_IN,
           MEMWBRdest, EXMEMRdest, cwMEM_in, Rdest_in,
    output busy, ALUres, Bout, ImmOUT, NPC4_OUT, jPC, cwMEM, Rdest,
           valid_out, PC_sel
  );
endinterface

// File: rtl/execute_md.sv
// Execute stage: single-cycle ALU, branch resolution, and an iterative
// multiply/divide unit (one bit per cycle) that stalls the pipe while running.
module execute_md #(
  parameter int N   = 32,
  parameter int CWM = 7,
  parameter int RDW = 5
) (
  input  logic         clk,
  input  logic         rst,
  execute_md_if.slave  bus
);

  localparam int SHW = $clog2(N);
  localparam int CW  = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } br_e;

  state_e         state, state_next;

  logic [N-1:0]   fwd_a, fwd_b, op1, op2, alu_res, jpc_next;
  logic [SHW-1:0] shamt;
  logic           taken, pc_sel_next;
  logic           accept, busy, last_iter;

  // Latched mul/div context
  logic [N-1:0]   op_a_q;
  logic [2:0]     op_q;
  logic           s_a, s_b, b_zero;
  logic [N-1:0]   acc_hi, acc_lo, mag_b;
  logic [CW-1:0]  cnt;

  // Accept-time operand preparation
  logic           a_signed, b_signed, sa_in, sb_in;
  logic [N-1:0]   mag_a_in, mag_b_in;

  // Iteration datapath
  logic [N:0]     mul_sum, div_sh;
  logic           div_ge;
  logic [N-1:0]   div_diff;

  // Final result
  logic [2*N-1:0] prod, prod_s;
  logic [N-1:0]   quo_s, rem_s, md_res;

  // EX/MEM registers
  logic [N-1:0]   alu_q, bout_q, imm_q, npc4_q, jpc_q;
  logic [CWM-1:0] cw_q;
  logic [RDW-1:0] rd_q;
  logic           valid_q, pcsel_q;

  // Forwarding muxes and operand selection
  always_comb begin
    fwd_a = bus.r1;
    fwd_b = bus.r2;
    case (bus.forwardA)
      2'b01:   fwd_a = bus.MEMWBRdest;
      2'b10:   fwd_a = bus.EXMEMRdest;
      default: ;
    endcase
    case (bus.forwardB)
      2'b01:   fwd_b = bus.MEMWBRdest;
      2'b10:   fwd_b = bus.EXMEMRdest;
      default: ;
    endcase
    op1   = bus.selA ? fwd_a : bus.NPCin;
    op2   = bus.selB ? bus.Imm : fwd_b;
    shamt = op2[SHW-1:0];
  end

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (bus.aluOp)
      ALU_ADD:   alu_res = op1 + op2;
      ALU_SUB:   alu_res = op1 - op2;
      ALU_AND:   alu_res = op1 & op2;
      ALU_OR:    alu_res = op1 | op2;
      ALU_XOR:   alu_res = op1 ^ op2;
      ALU_SLL:   alu_res = op1 << shamt;
      ALU_SRL:   alu_res = op1 >> shamt;
      ALU_SRA:   alu_res = N'($signed(op1) >>> shamt);
      ALU_SLT:   alu_res = N'($signed(op1) < $signed(op2));
      ALU_SLTU:  alu_res = N'(op1 < op2);
      ALU_PASSB: alu_res = op2;
      default:   alu_res = '0;
    endcase
  end

  // Branch condition on forwarded register values and redirect target
  always_comb begin
    taken = 1'b0;
    case (bus.branch)
      BR_EQ:   taken = (fwd_a == fwd_b);
      BR_NE:   taken = (fwd_a != fwd_b);
      BR_LT:   taken = ($signed(fwd_a) <  $signed(fwd_b));
      BR_GE:   taken = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  taken = (fwd_a <  fwd_b);
      BR_GEU:  taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
    pc_sel_next = bus.valid_in & (bus.jmp_en | taken);
    jpc_next    = bus.NPCin + (bus.Imm << 1);
  end

  assign accept    = (state == IDLE) & bus.valid_in & bus.md_en & bus.pipe_en
                     & ~bus.flush & ~rst;
  assign busy      = accept | (state == RUN);
  assign last_iter = (cnt == CW'(N - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic; flush overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (bus.pipe_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // Signedness and magnitudes of the operands captured at accept
  always_comb begin
    a_signed = (bus.md_op == MD_MUL) || (bus.md_op == MD_MULH) ||
               (bus.md_op == MD_MULHSU) || (bus.md_op == MD_DIV) ||
               (bus.md_op == MD_REM);
    b_signed = (bus.md_op == MD_MUL) || (bus.md_op == MD_MULH) ||
               (bus.md_op == MD_DIV) || (bus.md_op == MD_REM);
    sa_in    = a_signed & fwd_a[N-1];
    sb_in    = b_signed & fwd_b[N-1];
    mag_a_in = sa_in ? -fwd_a : fwd_a;
    mag_b_in = sb_in ? -fwd_b : fwd_b;
  end

  // One shift-add or restoring-divide step on the magnitude registers
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    div_sh   = {acc_hi, acc_lo[N-1]};
    div_ge   = (div_sh >= {1'b0, mag_b});
    div_diff = div_sh[N-1:0] - mag_b;
  end

  // Mul/div working registers: acc_hi/acc_lo hold product or remainder/quotient
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= '0;
      op_q   <= '0;
      s_a    <= 1'b0;
      s_b    <= 1'b0;
      b_zero <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_b  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      op_a_q <= fwd_a;
      op_q   <= bus.md_op;
      s_a    <= sa_in;
      s_b    <= sb_in;
      b_zero <= (fwd_b == '0);
      acc_hi <= '0;
      acc_lo <= mag_a_in;
      mag_b  <= mag_b_in;
      cnt    <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      if (op_q[2]) begin
        if (div_ge) begin
          acc_hi <= div_diff;
          acc_lo <= {acc_lo[N-2:0], 1'b1};
        end else begin
          acc_hi <= div_sh[N-1:0];
          acc_lo <= {acc_lo[N-2:0], 1'b0};
        end
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[N-1:1]};
      end
    end
  end

  // Sign fix-up and result selection. -2^(N-1)/-1 needs no special case:
  // the magnitude quotient is 2^(N-1), both signs negative, so it is left
  // un-negated and already reads as -2^(N-1) with a zero remainder.
  always_comb begin
    prod   = {acc_hi, acc_lo};
    prod_s = (s_a ^ s_b) ? -prod : prod;
    quo_s  = (s_a ^ s_b) ? -acc_lo : acc_lo;
    rem_s  = s_a ? -acc_hi : acc_hi;
    case (op_q)
      MD_MUL:                       md_res = prod_s[N-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_res = prod_s[2*N-1:N];
      MD_DIV, MD_DIVU:              md_res = b_zero ? '1 : quo_s;
      default:                      md_res = b_zero ? op_a_q : rem_s;
    endcase
  end

  // EX/MEM pipeline registers: flush kills validity, load only when not stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      bout_q  <= '0;
      imm_q   <= '0;
      npc4_q  <= '0;
      jpc_q   <= '0;
      cw_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      pcsel_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      pcsel_q <= 1'b0;
    end else if (bus.pipe_en && !busy) begin
      alu_q   <= (state == DONE) ? md_res : alu_res;
      bout_q  <= fwd_b;
      imm_q   <= bus.Imm;
      npc4_q  <= bus.NPC4_IN;
      jpc_q   <= jpc_next;
      cw_q    <= bus.cwMEM_in;
      rd_q    <= bus.Rdest_in;
      valid_q <= bus.valid_in;
      pcsel_q <= pc_sel_next;
    end
  end

  assign bus.busy      = busy;
  assign bus.ALUres    = alu_q;
  assign bus.Bout      = bout_q;
  assign bus.ImmOUT    = imm_q;
  assign bus.NPC4_OUT  = npc4_q;
  assign bus.jPC       = jpc_q;
  assign bus.cwMEM     = cw_q;
  assign bus.Rdest     = rd_q;
  assign bus.valid_out = valid_q;
  assign bus.PC_sel    = pcsel_q;

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md at N = 32.
module tb_execute_md;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc;

  always #5 clk = ~clk;

  execute_md_if #(.N(N), .CWM(7), .RDW(5)) bus ();

  execute_md #(.N(N), .CWM(7), .RDW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.pipe_en    = 1'b1;
    bus.flush      = 1'b0;
    bus.valid_in   = 1'b0;
    bus.aluOp      = 4'd0;
    bus.md_en      = 1'b0;
    bus.md_op      = 3'd0;
    bus.selA       = 1'b1;
    bus.selB       = 1'b0;
    bus.branch     = 3'd0;
    bus.jmp_en     = 1'b0;
    bus.forwardA   = 2'b00;
    bus.forwardB   = 2'b00;
    bus.r1         = '0;
    bus.r2         = '0;
    bus.Imm        = '0;
    bus.NPCin      = '0;
    bus.NPC4_IN    = '0;
    bus.MEMWBRdest = '0;
    bus.EXMEMRdest = '0;
    bus.cwMEM_in   = '0;
    bus.Rdest_in   = '0;
  endtask

  // Counts consecutive busy cycles, bounded so a stuck busy cannot hang the run
  task automatic wait_busy(output int c);
    c = 0;
    #1;
    while (bus.busy === 1'b1 && c < 100) begin
      c++;
      step();
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp);
    int c;
    clear_in();
    bus.valid_in = 1'b1;
    bus.md_en    = 1'b1;
    bus.md_op    = op;
    bus.r1       = a;
    bus.r2       = b;
    bus.Rdest_in = 5'd9;
    bus.cwMEM_in = 7'h11;
    wait_busy(c);
    chk({tag, "_busy_cycles"}, 32'(c), 32'd33);
    step();
    chk(tag, bus.ALUres, exp);
    chkb({tag, "_valid"}, bus.valid_out, 1'b1);
    chk({tag, "_rdest"}, 32'(bus.Rdest), 32'd9);
    clear_in();
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    step();
    step();
    // Reset state; mul/div request presented while rst is high must not stall
    chk("rst_alures", bus.ALUres, 32'h0);
    chkb("rst_valid", bus.valid_out, 1'b0);
    chkb("rst_pcsel", bus.PC_sel, 1'b0);
    chk("rst_jpc", bus.jPC, 32'h0);
    chk("rst_cw", 32'(bus.cwMEM), 32'h0);
    bus.valid_in = 1'b1;
    bus.md_en    = 1'b1;
    #1;
    chkb("rst_busy", bus.busy, 1'b0);
    clear_in();
    rst = 1'b0;

    // ADD r1 + r2 with full EX/MEM field propagation
    bus.valid_in = 1'b1;
    bus.r1 = 32'd5; bus.r2 = 32'd7;
    bus.cwMEM_in = 7'h55; bus.Rdest_in = 5'd3;
    bus.NPC4_IN = 32'h104; bus.Imm = 32'h10;
    #1;
    chkb("add_busy", bus.busy, 1'b0);
    step();
    chk("add_res", bus.ALUres, 32'd12);
    chkb("add_valid", bus.valid_out, 1'b1);
    chk("add_cw", 32'(bus.cwMEM), 32'h55);
    chk("add_rdest", 32'(bus.Rdest), 32'd3);
    chk("add_npc4", bus.NPC4_OUT, 32'h104);
    chk("add_imm", bus.ImmOUT, 32'h10);
    chk("add_bout", bus.Bout, 32'd7);

    // SUB with forwarded A (EX/MEM) and immediate B; Bout takes MEM/WB forward
    bus.aluOp = 4'd1; bus.forwardA = 2'b10; bus.EXMEMRdest = 32'h40;
    bus.selB = 1'b1; bus.Imm = 32'd8;
    bus.forwardB = 2'b01; bus.MEMWBRdest = 32'h77;
    step();
    chk("sub_fwd", bus.ALUres, 32'h38);
    chk("bout_fwd", bus.Bout, 32'h77);

    // Forward code 11 falls back to the register value
    clear_in();
    bus.valid_in = 1'b1; bus.forwardA = 2'b11;
    bus.r1 = 32'd10; bus.r2 = 32'd1;
    bus.MEMWBRdest = 32'd99; bus.EXMEMRdest = 32'd77;
    step();
    chk("fwd11", bus.ALUres, 32'd11);

    // SRA of a negative value, SLT signed, selA = NPCin
    clear_in();
    bus.valid_in = 1'b1; bus.aluOp = 4'd7; bus.r1 = 32'h8000_0000;
    bus.selB = 1'b1; bus.Imm = 32'd4;
    step();
    chk("sra", bus.ALUres, 32'hF800_0000);
    bus.aluOp = 4'd8; bus.selB = 1'b0; bus.r1 = 32'hFFFF_FFFF; bus.r2 = 32'd1;
    step();
    chk("slt", bus.ALUres, 32'd1);
    bus.aluOp = 4'd0; bus.selA = 1'b0; bus.NPCin = 32'h200;
    step();
    chk("npc_plus_r2", bus.ALUres, 32'h201);

    // pipe_en low: EX/MEM holds
    bus.pipe_en = 1'b0; bus.selA = 1'b1; bus.r1 = 32'd100;
    step();
    chk("hold_pipe_en", bus.ALUres, 32'h201);

    // Branches on r1 = 1, r2 = -1
    clear_in();
    bus.valid_in = 1'b1; bus.r1 = 32'd1; bus.r2 = 32'hFFFF_FFFF;
    bus.NPCin = 32'h1000; bus.Imm = 32'h20; bus.branch = 3'd5;
    step();
    chkb("bltu_taken", bus.PC_sel, 1'b1);
    chk("bltu_jpc", bus.jPC, 32'h1040);
    bus.branch = 3'd3;
    step();
    chkb("blt_not", bus.PC_sel, 1'b0);
    bus.branch = 3'd4;
    step();
    chkb("bge_taken", bus.PC_sel, 1'b1);
    bus.branch = 3'd1; bus.forwardB = 2'b01; bus.MEMWBRdest = 32'd1;
    step();
    chkb("beq_fwd", bus.PC_sel, 1'b1);
    bus.branch = 3'd7;
    step();
    chkb("br7_not", bus.PC_sel, 1'b0);
    bus.branch = 3'd0; bus.jmp_en = 1'b1;
    bus.NPCin = 32'h10; bus.Imm = 32'h8000_0001;
    step();
    chkb("jmp_taken", bus.PC_sel, 1'b1);
    chk("jpc_wrap", bus.jPC, 32'h12);
    bus.valid_in = 1'b0;
    step();
    chkb("inv_pcsel", bus.PC_sel, 1'b0);
    chkb("inv_valid", bus.valid_out, 1'b0);

    // Mul/div directed vectors
    run_md("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_md("divu_z", 3'd5, 32'h1234, 32'h0, 32'hFFFF_FFFF);
    run_md("remu_z", 3'd7, 32'h1234, 32'h0, 32'h1234);
    run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("div_neg", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    run_md("rem_neg", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    run_md("mulh_neg", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_md("div_z", 3'd4, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFFF);

    // Flush at RUN cycle 10, then an ADD completes in one cycle
    clear_in();
    bus.valid_in = 1'b1; bus.md_en = 1'b1; bus.md_op = 3'd4;
    bus.r1 = 32'd1000; bus.r2 = 32'd3;
    #1;
    chkb("flush_accept_busy", bus.busy, 1'b1);
    for (int i = 0; i < 10; i++) step();
    chkb("flush_run_busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    step();
    clear_in();
    bus.valid_in = 1'b1; bus.r1 = 32'd20; bus.r2 = 32'd22;
    #1;
    chkb("flush_busy", bus.busy, 1'b0);
    chkb("flush_valid", bus.valid_out, 1'b0);
    chkb("flush_pcsel", bus.PC_sel, 1'b0);
    step();
    chk("post_flush_add", bus.ALUres, 32'd42);
    chkb("post_flush_valid", bus.valid_out, 1'b1);

    // Operands change during RUN; result held in DONE while pipe_en is low
    clear_in();
    bus.valid_in = 1'b1; bus.md_en = 1'b1; bus.md_op = 3'd4;
    bus.r1 = 32'd100; bus.r2 = 32'd7;
    step();
    bus.forwardA = 2'b10; bus.EXMEMRdest = 32'h5000;
    bus.r1 = 32'hDEAD; bus.r2 = 32'd1;
    wait_busy(cyc);
    chk("hold_run_cycles", 32'(cyc), 32'd32);
    bus.pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("done_hold_res", bus.ALUres, 32'd42);
      chkb("done_hold_busy", bus.busy, 1'b0);
    end
    bus.pipe_en = 1'b1;
    step();
    chk("done_load_res", bus.ALUres, 32'd14);
    chkb("done_load_valid", bus.valid_out, 1'b1);
    clear_in();

    // Reset mid-RUN, then a full multiply must take the full latency again
    bus.valid_in = 1'b1; bus.md_en = 1'b1; bus.md_op = 3'd0;
    bus.r1 = 32'd3; bus.r2 = 32'd4;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    chk("midrst_res", bus.ALUres, 32'h0);
    chkb("midrst_valid", bus.valid_out, 1'b0);
    chkb("midrst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    clear_in();
    bus.valid_in = 1'b1; bus.r1 = 32'd1; bus.r2 = 32'd2;
    step();
    chk("postrst_add", bus.ALUres, 32'd3);
    run_md("postrst_mul", 3'd0, 32'd3, 32'd4, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
